// File: rtl/noc_params_pkg.sv
// Router-wide parameters shared by the allocator and its neighbours.
package noc_params_pkg;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;

endpackage

// File: rtl/rr_arbiter_upd.sv
// Round-robin arbiter whose priority pointer moves only when the caller
// confirms that the grant was actually used (update_en).
module rr_arbiter_upd #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          update_en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] ptr;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin : arb_comb
        int k;
        k       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!gnt_any && req[k]) begin
                gnt_any = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end

    // Winner drops to lowest priority, but only for grants that were used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (update_en && gnt_any) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with per-output wormhole locking.
// Stage 1 picks one VC per input, stage 2 picks one input per output.
module switch_allocator #(
    parameter int  PORT_NUM  = noc_params_pkg::PORT_NUM,
    parameter int  VC_NUM    = noc_params_pkg::VC_NUM,
    localparam int PORT_SIZE = $clog2(PORT_NUM),
    localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                tail_i,
    output logic [PORT_NUM-1:0]                         in_grant_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]            in_vc_o,
    output logic [PORT_NUM-1:0]                         xbar_valid_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]          xbar_sel_o
);

    // Per-output packet lock and its owner (input, VC).
    logic [PORT_NUM-1:0]  lock_q;
    logic [PORT_SIZE-1:0] owner_p_q [PORT_NUM];
    logic [VC_SIZE-1:0]   owner_v_q [PORT_NUM];

    logic [VC_NUM-1:0]    elig      [PORT_NUM];
    logic [VC_NUM-1:0]    s1_gnt    [PORT_NUM];
    logic [VC_SIZE-1:0]   s1_idx    [PORT_NUM];
    logic [PORT_NUM-1:0]  s1_any;
    logic [PORT_SIZE-1:0] cand_port [PORT_NUM];

    logic [PORT_NUM-1:0]  s2_req    [PORT_NUM];
    logic [PORT_NUM-1:0]  s2_gnt    [PORT_NUM];
    logic [PORT_SIZE-1:0] s2_idx    [PORT_NUM];
    logic [PORT_NUM-1:0]  s2_any;

    logic [PORT_NUM-1:0]  in_grant;

    // A VC may compete only for a legal output that is free or already its own.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                elig[p][v] = 1'b0;
                if (request_i[p][v] && (int'(out_port_i[p][v]) < PORT_NUM)) begin
                    elig[p][v] = !lock_q[out_port_i[p][v]] ||
                                 ((owner_p_q[out_port_i[p][v]] == PORT_SIZE'(p)) &&
                                  (owner_v_q[out_port_i[p][v]] == VC_SIZE'(v)));
                end
            end
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_stage1
        rr_arbiter_upd #(.N(VC_NUM)) u_vc_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (elig[p]),
            .update_en (in_grant[p]),
            .gnt       (s1_gnt[p]),
            .gnt_idx   (s1_idx[p]),
            .gnt_any   (s1_any[p])
        );
    end

    // Route each input's stage-1 winner to the output it targets.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            cand_port[p] = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                if (s1_gnt[p][v]) cand_port[p] = cand_port[p] | out_port_i[p][v];
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                s2_req[o][p] = s1_any[p] && (cand_port[p] == PORT_SIZE'(o));
            end
        end
    end

    // A locked output only ever sees its owner's request, so the arbiter
    // simply passes it through; its pointer moves only on unlocked grants.
    for (genvar o = 0; o < PORT_NUM; o++) begin : g_stage2
        rr_arbiter_upd #(.N(PORT_NUM)) u_in_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (s2_req[o]),
            .update_en (!lock_q[o]),
            .gnt       (s2_gnt[o]),
            .gnt_idx   (s2_idx[o]),
            .gnt_any   (s2_any[o])
        );
    end

    // Collect per-input grants and drive dequeue and crossbar selects.
    always_comb begin
        in_grant = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            in_grant = in_grant | s2_gnt[o];
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            in_vc_o[p] = in_grant[p] ? s1_idx[p] : '0;
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            xbar_sel_o[o] = s2_idx[o];
        end
        in_grant_o   = in_grant;
        xbar_valid_o = s2_any;
    end

    // Head/body grants lock the output to the sender; a tail grant releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
            for (int o = 0; o < PORT_NUM; o++) begin
                owner_p_q[o] <= '0;
                owner_v_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (s2_any[o]) begin
                    if (tail_i[s2_idx[o]][s1_idx[s2_idx[o]]]) begin
                        lock_q[o] <= 1'b0;
                    end else begin
                        lock_q[o]    <= 1'b1;
                        owner_p_q[o] <= s2_idx[o];
                        owner_v_q[o] <= s1_idx[s2_idx[o]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator using an expectation queue.
module tb_switch_allocator;

    logic                 clk;
    logic                 rst;
    logic [4:0][1:0]      request;
    logic [4:0][1:0][2:0] out_port;
    logic [4:0][1:0]      tail;
    logic [4:0]           in_grant;
    logic [4:0][0:0]      in_vc;
    logic [4:0]           xbar_valid;
    logic [4:0][2:0]      xbar_sel;

    typedef struct {
        string       tag;
        logic [4:0]  gnt;
        logic [4:0]  vc;
        logic [4:0]  xv;
        logic [14:0] xs;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    switch_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .request_i    (request),
        .out_port_i   (out_port),
        .tail_i       (tail),
        .in_grant_o   (in_grant),
        .in_vc_o      (in_vc),
        .xbar_valid_o (xbar_valid),
        .xbar_sel_o   (xbar_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] sel(input int o, input int p);
        logic [14:0] r;
        r = '0;
        r[o*3 +: 3] = 3'(p);
        return r;
    endfunction

    task automatic clr();
        request  = '0;
        out_port = '0;
        tail     = '0;
    endtask

    task automatic rq(input int p, input int v, input int port, input logic t);
        request[p][v]  = 1'b1;
        out_port[p][v] = 3'(port);
        tail[p][v]     = t;
    endtask

    task automatic check(input string tag, input string fld,
                         input logic [14:0] obs, input logic [14:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    // Queue the expectation for the inputs just driven, then compare at negedge.
    task automatic step(input string tag, input logic [4:0] g, input logic [4:0] vc,
                        input logic [4:0] xv, input logic [14:0] xs);
        exp_t        e;
        logic [14:0] m;
        logic [4:0]  vc_obs;
        e.tag = tag; e.gnt = g; e.vc = vc; e.xv = xv; e.xs = xs;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        m = '0;
        for (int o = 0; o < 5; o++) if (e.xv[o]) m[o*3 +: 3] = 3'b111;
        vc_obs = in_vc;
        check(e.tag, "in_grant",   {10'b0, in_grant},   {10'b0, e.gnt});
        check(e.tag, "in_vc",      {10'b0, vc_obs & e.gnt}, {10'b0, e.vc & e.gnt});
        check(e.tag, "xbar_valid", {10'b0, xbar_valid}, {10'b0, e.xv});
        check(e.tag, "xbar_sel",   xbar_sel & m,        e.xs & m);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        #1;
        step("reset", 5'b0, 5'b0, 5'b0, 15'b0);
        rst = 1'b0;

        // single-flit packet, then another input takes the same output
        rq(0, 0, 2, 1'b1);
        step("single", 5'b00001, 5'b0, 5'b00100, sel(2, 0));
        clr();
        step("idle", 5'b0, 5'b0, 5'b0, 15'b0);
        rq(1, 0, 2, 1'b1);
        step("unlocked2", 5'b00010, 5'b0, 5'b00100, sel(2, 1));

        // two inputs contend for output 4 with single-flit packets
        clr();
        rq(1, 0, 4, 1'b1);
        rq(3, 0, 4, 1'b1);
        step("rr_a", 5'b00010, 5'b0, 5'b10000, sel(4, 1));
        step("rr_b", 5'b01000, 5'b0, 5'b10000, sel(4, 3));
        step("rr_c", 5'b00010, 5'b0, 5'b10000, sel(4, 1));
        step("rr_d", 5'b01000, 5'b0, 5'b10000, sel(4, 3));

        // wormhole lock on output 1 by input 0 VC1
        clr();
        rq(0, 1, 1, 1'b0);
        step("head", 5'b00001, 5'b00001, 5'b00010, sel(1, 0));
        rq(2, 0, 1, 1'b1);
        step("body", 5'b00001, 5'b00001, 5'b00010, sel(1, 0));
        request[0][1] = 1'b0;
        rq(4, 0, 1, 1'b1);
        step("stall_a", 5'b0, 5'b0, 5'b0, 15'b0);
        step("stall_b", 5'b0, 5'b0, 5'b0, 15'b0);
        step("stall_c", 5'b0, 5'b0, 5'b0, 15'b0);
        rq(0, 1, 1, 1'b1);
        step("tail", 5'b00001, 5'b00001, 5'b00010, sel(1, 0));
        request[0][1] = 1'b0;
        step("after_tail", 5'b00100, 5'b0, 5'b00010, sel(1, 2));

        // input 3 locks output 1; input 0 VC0 blocked, VC1 wins output 2
        clr();
        rq(3, 0, 1, 1'b0);
        step("lock3", 5'b01000, 5'b0, 5'b00010, sel(1, 3));
        rq(0, 0, 1, 1'b1);
        rq(0, 1, 2, 1'b1);
        step("vc_bypass", 5'b01001, 5'b00001, 5'b00110, sel(1, 3) | sel(2, 0));
        clr();
        rq(0, 0, 1, 1'b1);
        step("still_locked", 5'b0, 5'b0, 5'b0, 15'b0);

        // lock output 3, then pulse reset mid-cycle and bring a new requester
        clr();
        rq(2, 0, 3, 1'b0);
        step("lock_out3", 5'b00100, 5'b0, 5'b01000, sel(3, 2));
        clr();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        rq(4, 1, 3, 1'b0);
        rq(1, 0, 6, 1'b1);
        rq(0, 0, 1, 1'b1);
        step("post_reset", 5'b10001, 5'b10000, 5'b01010, sel(3, 4) | sel(1, 0));
        clr();
        rq(1, 1, 5, 1'b1);
        rq(4, 1, 3, 1'b1);
        step("bad_port", 5'b10000, 5'b10000, 5'b01000, sel(3, 4));
        clr();
        step("final_idle", 5'b0, 5'b0, 5'b0, 15'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
